// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard beside ID: tracks in-flight destinations per stage and derives
// forwarding selects, load-use / multi-cycle / CSR-serialisation stalls and branch/trap flushes.
module hazard_scoreboard #(
    parameter int unsigned RegW      = 5,
    parameter int unsigned NumStages = 3,
    parameter int unsigned LoadLat   = 1,
    parameter int unsigned McMax     = 63
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             id_valid_i,
    input  logic [RegW-1:0]                  id_rs1_i,
    input  logic [RegW-1:0]                  id_rs2_i,
    input  logic                             id_use_rs1_i,
    input  logic                             id_use_rs2_i,
    input  logic [RegW-1:0]                  id_rd_i,
    input  logic                             id_rd_we_i,
    input  logic                             id_is_load_i,
    input  logic                             id_is_mc_i,
    input  logic                             id_csr_serial_i,
    input  logic                             mc_done_i,
    input  logic                             took_branch_i,
    input  logic                             any_excep_i,
    input  logic                             ret_i,
    output logic [$clog2(NumStages+1)-1:0]   fwd_sel_a_o,
    output logic [$clog2(NumStages+1)-1:0]   fwd_sel_b_o,
    output logic                             stall_if_o,
    output logic                             stall_id_o,
    output logic                             flush_if_o,
    output logic                             flush_id_o,
    output logic                             flush_ex_o,
    output logic                             flush_mem_o,
    output logic                             issue_o,
    output logic                             mc_timeout_o
);

    localparam int unsigned SelW = $clog2(NumStages + 1);
    localparam int unsigned CntW = $clog2(McMax + 2);

    typedef struct packed {
        logic            v;
        logic [RegW-1:0] rd;
        logic            we;
        logic            is_load;
    } entry_t;

    typedef enum logic [1:0] {StRun, StMcWait, StDrain} state_e;

    entry_t          sb_q [1:NumStages];
    entry_t          sb_d [1:NumStages];
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [SelW-1:0] sel_a, sel_b;
    logic            ld_a, ld_b, any_v;
    logic            flush_br, flush_xr, flush_any;
    logic            hold_c, stall_c, issue_c;

    function automatic logic match(entry_t e, logic [RegW-1:0] rs, logic use_rs);
        return e.v && e.we && (e.rd == rs) && (rs != '0) && use_rs;
    endfunction

    // Scan oldest to youngest so the youngest matching producer is the last one written.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        any_v = 1'b0;
        for (int k = int'(NumStages); k >= 1; k--) begin
            if (match(sb_q[k], id_rs1_i, id_use_rs1_i)) begin
                sel_a = SelW'(k);
                ld_a  = sb_q[k].is_load && (k <= int'(LoadLat));
            end
            if (match(sb_q[k], id_rs2_i, id_use_rs2_i)) begin
                sel_b = SelW'(k);
                ld_b  = sb_q[k].is_load && (k <= int'(LoadLat));
            end
            any_v = any_v | sb_q[k].v;
        end
    end

    always_comb begin
        flush_br  = took_branch_i;
        flush_xr  = (any_excep_i | ret_i) & ~took_branch_i;
        flush_any = flush_br | flush_xr;
        // In DRAIN the held CSR may go as soon as the pipe is empty.
        hold_c    = ld_a | ld_b | (state_q == StMcWait) |
                    ((state_q == StDrain) ? any_v : (id_csr_serial_i & any_v));
        stall_c   = id_valid_i & hold_c & ~flush_any;
        issue_c   = id_valid_i & ~hold_c & ~flush_any;
    end

    // Next-state: FSM and timeout counter
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (issue_c && id_is_mc_i) begin
                    state_d = StMcWait;
                    cnt_d   = '0;
                end else if (id_valid_i && id_csr_serial_i && any_v) begin
                    state_d = StDrain;
                end
            end
            StMcWait: begin
                if (mc_done_i) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else if (cnt_q != CntW'(McMax + 1)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (!any_v) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
        if (flush_any) begin
            state_d = StRun;
            cnt_d   = '0;
        end
    end

    // Next-state: scoreboard entries (frozen while EX is held by the multi-cycle unit)
    always_comb begin
        sb_d = sb_q;
        if (state_q != StMcWait) begin
            for (int k = int'(NumStages); k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            sb_d[1] = issue_c ? '{v: 1'b1, rd: id_rd_i, we: id_rd_we_i, is_load: id_is_load_i}
                              : '0;
        end
        if (flush_br) begin
            sb_d[1] = '0;
        end else if (flush_xr) begin
            sb_d[1] = '0;
            sb_d[2] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 1; k <= int'(NumStages); k++) begin
                sb_q[k] <= '0;
            end
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            sb_q    <= sb_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        fwd_sel_a_o  = reset_i ? '0 : sel_a;
        fwd_sel_b_o  = reset_i ? '0 : sel_b;
        stall_if_o   = ~reset_i & stall_c;
        stall_id_o   = ~reset_i & stall_c;
        flush_if_o   = ~reset_i & flush_br;
        flush_id_o   = ~reset_i & flush_any;
        flush_ex_o   = ~reset_i & flush_xr;
        flush_mem_o  = ~reset_i & flush_xr;
        issue_o      = ~reset_i & issue_c;
        mc_timeout_o = ~reset_i & (state_q == StMcWait) & (cnt_q == CntW'(McMax));
    end

endmodule
